// File: rtl/mii_rx_deframer.sv
// Generic FIFO with the head visible combinationally (zero when empty); 1 clk write-to-head.
// Writes while full and reads while empty are ignored; the writer must check full_o first.
module mii_rx_fifo #(
    parameter int W  = 10,
    parameter int AW = 6
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         wr_vld_i,
    input  logic [W-1:0] wr_dat_i,
    output logic         full_o,
    output logic         rd_vld_o,
    input  logic         rd_rdy_i,
    output logic [W-1:0] rd_dat_o
);
    logic [W-1:0] mem_q [0:(1<<AW)-1];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         empty, do_wr, do_rd;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr    = wr_vld_i && !full_o;
    assign do_rd    = rd_rdy_i && !empty;
    assign rd_vld_o = !empty;
    assign rd_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end
endmodule

// MII RX deframer: syncs MII pins into clk, strips preamble/SFD, packs nibbles into sof/eof-tagged bytes.
// Pin-to-strobe 3 clk, bytes held one byte-time for eof tagging; no MII backpressure, overflow drops the frame.
module mii_rx_deframer #(
    parameter int FIFO_AW = 6,
    parameter int MIN_PRE = 4,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk,
    input  logic        SW0,
    input  logic        mii_clk,
    input  logic        mii_en,
    input  logic [0:3]  mii_d,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] frame_count,
    output logic        err_pulse,
    output logic [1:0]  err_code
);
    localparam int PW = $clog2(MIN_PRE + 2);
    localparam int BW = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] dat;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    logic [3:0]    nib_pin;
    logic [1:0]    clk_sync_q, en_sync_q;
    logic [3:0]    d_s1_q, d_s2_q, nib_q;
    logic          clk_prev_q, strobe_q, en_q;

    state_t        state_q;
    logic [PW-1:0] pre_cnt_q;
    logic [BW-1:0] byte_cnt_q;
    logic          phase_q, held_vld_q, held_sof_q;
    logic [3:0]    low_q;
    logic [7:0]    held_q;
    logic [15:0]   frame_cnt_q;
    logic          err_pulse_q;
    logic [1:0]    err_code_q;
    logic          wr_vld_q, fifo_full;
    entry_t        wr_dat_q, head;

    // Bit 0 of the byte arrives on mii_d[0], which is the MSB of the [0:3] port.
    assign nib_pin = {mii_d[3], mii_d[2], mii_d[1], mii_d[0]};

    always_ff @(posedge clk) begin
        if (SW0) begin
            clk_sync_q <= '0;
            en_sync_q  <= '0;
            d_s1_q     <= '0;
            d_s2_q     <= '0;
            clk_prev_q <= 1'b0;
            strobe_q   <= 1'b0;
            en_q       <= 1'b0;
            nib_q      <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], mii_clk};
            en_sync_q  <= {en_sync_q[0], mii_en};
            d_s1_q     <= nib_pin;
            d_s2_q     <= d_s1_q;
            clk_prev_q <= clk_sync_q[1];
            strobe_q   <= clk_sync_q[1] & ~clk_prev_q;
            en_q       <= en_sync_q[1];
            nib_q      <= d_s2_q;
        end
    end

    // Reset parks in DROP so a frame already on the wire at release is ignored.
    always_ff @(posedge clk) begin
        if (SW0) begin
            state_q     <= S_DROP;
            pre_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            phase_q     <= 1'b0;
            held_vld_q  <= 1'b0;
            held_sof_q  <= 1'b0;
            low_q       <= '0;
            held_q      <= '0;
            frame_cnt_q <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            wr_vld_q    <= 1'b0;
            wr_dat_q    <= '0;
        end else begin
            wr_vld_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            if (strobe_q) begin
                case (state_q)
                    S_IDLE: if (en_q) begin
                        if (nib_q == 4'h5) begin
                            state_q   <= S_PRE;
                            pre_cnt_q <= PW'(1);
                        end else begin
                            state_q     <= S_DROP;
                            err_pulse_q <= 1'b1;
                            err_code_q  <= 2'd1;
                        end
                    end
                    S_PRE: begin
                        if (!en_q) begin
                            state_q     <= S_IDLE;
                            err_pulse_q <= 1'b1;
                            err_code_q  <= 2'd1;
                        end else if (nib_q == 4'h5) begin
                            if (pre_cnt_q < PW'(MIN_PRE)) pre_cnt_q <= pre_cnt_q + PW'(1);
                        end else if (nib_q == 4'hD && pre_cnt_q >= PW'(MIN_PRE)) begin
                            state_q    <= S_DATA;
                            phase_q    <= 1'b0;
                            held_vld_q <= 1'b0;
                            byte_cnt_q <= '0;
                        end else begin
                            state_q     <= S_DROP;
                            err_pulse_q <= 1'b1;
                            err_code_q  <= 2'd1;
                        end
                    end
                    S_DATA: begin
                        if (!en_q) begin
                            state_q <= S_IDLE;
                            if (held_vld_q && fifo_full) begin
                                err_pulse_q <= 1'b1;
                                err_code_q  <= 2'd3;
                            end else begin
                                if (held_vld_q) begin
                                    wr_vld_q <= 1'b1;
                                    wr_dat_q <= {held_sof_q, 1'b1, held_q};
                                end
                                if (phase_q) begin
                                    err_pulse_q <= 1'b1;
                                    err_code_q  <= 2'd2;
                                end else begin
                                    frame_cnt_q <= frame_cnt_q + 16'd1;
                                end
                            end
                        end else if (!phase_q) begin
                            low_q   <= nib_q;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (byte_cnt_q == BW'(MAX_LEN) || (held_vld_q && fifo_full)) begin
                                state_q     <= S_DROP;
                                err_pulse_q <= 1'b1;
                                err_code_q  <= 2'd3;
                            end else begin
                                if (held_vld_q) begin
                                    wr_vld_q <= 1'b1;
                                    wr_dat_q <= {held_sof_q, 1'b0, held_q};
                                end
                                held_q     <= {nib_q, low_q};
                                held_sof_q <= (byte_cnt_q == '0);
                                held_vld_q <= 1'b1;
                                byte_cnt_q <= byte_cnt_q + BW'(1);
                            end
                        end
                    end
                    S_DROP: if (!en_q) state_q <= S_IDLE;
                endcase
            end
        end
    end

    mii_rx_fifo #(
        .W  ($bits(entry_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst_i    (SW0),
        .wr_vld_i (wr_vld_q),
        .wr_dat_i (wr_dat_q),
        .full_o   (fifo_full),
        .rd_vld_o (out_valid),
        .rd_rdy_i (out_ready),
        .rd_dat_o (head)
    );

    assign out_data    = head.dat;
    assign out_sof     = head.sof;
    assign out_eof     = head.eof;
    assign frame_count = frame_cnt_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_mii_rx_deframer.sv
// Directed bench for mii_rx_deframer: expected bytes go into a scoreboard queue, a monitor pops on handshake.
module tb_mii_rx_deframer;
    logic        clk = 1'b0;
    logic        SW0 = 1'b1;
    logic        mii_clk = 1'b0;
    logic        mii_en = 1'b0;
    logic [0:3]  mii_d = '0;
    logic [7:0]  out_data;
    logic        out_sof, out_eof, out_valid, out_ready, err_pulse;
    logic [15:0] frame_count;
    logic [1:0]  err_code;

    logic        ready_base = 1'b0;
    logic        toggle_en  = 1'b0;
    logic        tog_ph     = 1'b0;
    int          n_chk = 0, n_fail = 0, err_seen = 0, e0 = 0;
    logic [9:0]  exp_q [$];

    assign out_ready = toggle_en ? tog_ph : ready_base;

    mii_rx_deframer #(.FIFO_AW(5), .MIN_PRE(4), .MAX_LEN(1522)) dut (
        .clk         (clk),
        .SW0         (SW0),
        .mii_clk     (mii_clk),
        .mii_en      (mii_en),
        .mii_d       (mii_d),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_count (frame_count),
        .err_pulse   (err_pulse),
        .err_code    (err_code)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Test frame: dst, src, type, 32 payload bytes 00..1f, CRC.
    function automatic logic [7:0] fbyte(input int i);
        logic [7:0] b;
        case (i)
            0: b = 8'h54;  1: b = 8'hff;  2: b = 8'h01;  3: b = 8'h21;
            4: b = 8'h23;  5: b = 8'h24;  6: b = 8'h12;  7: b = 8'h34;
            8: b = 8'h56;  9: b = 8'h78; 10: b = 8'h9a; 11: b = 8'hbc;
           12: b = 8'h12; 13: b = 8'h34;
           46: b = 8'hfb; 47: b = 8'h02; 48: b = 8'h90; 49: b = 8'h64;
           default: b = 8'(i - 14);
        endcase
        return b;
    endfunction

    task automatic send_nib(input logic en, input logic [3:0] n);
        mii_en = en;
        mii_d  = {n[0], n[1], n[2], n[3]};
        #20 mii_clk = 1'b1;
        #20 mii_clk = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_nib(1'b0, 4'h0);
    endtask

    task automatic push_frame(input int nbytes, input logic eof_last);
        for (int i = 0; i < nbytes; i++)
            exp_q.push_back({(i == 0), (eof_last && i == nbytes - 1), fbyte(i)});
    endtask

    // pre5 nibbles of 5, one SFD-high nibble, nnib data nibbles; reset pulse before nibble abort_at.
    task automatic send_frame(input int pre5, input logic [3:0] sfd, input int nnib, input int abort_at);
        logic [7:0] b;
        for (int i = 0; i < pre5; i++) send_nib(1'b1, 4'h5);
        send_nib(1'b1, sfd);
        for (int k = 0; k < nnib; k++) begin
            if (k == abort_at) begin
                @(negedge clk);
                check("s5 valid before reset", 32'(out_valid), 32'd1);
                SW0 = 1'b1;
                @(negedge clk);
                check("s5 valid after reset", 32'(out_valid), 32'd0);
                check("s5 head after reset", 32'({out_sof, out_eof, out_data}), 32'd0);
                SW0 = 1'b0;
            end
            b = fbyte(k / 2);
            send_nib(1'b1, (k % 2 == 0) ? b[3:0] : b[7:4]);
        end
        idle(12);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready_base = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 SW0 = 1'b1;
        repeat (2) @(posedge clk);
        #1 SW0 = 1'b0;
        idle(4);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check({name, " drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (8) @(negedge clk);
        check({name, " empty after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1 tog_ph = ~tog_ph;
        end
    end

    // Monitor: out_ready only changes just after a rising edge, so negedge sees the handshake value.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected byte: got sof=%0b eof=%0b data=0x%02h, expected none",
                             out_sof, out_eof, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte {sof,eof,data}", 32'({out_sof, out_eof, out_data}), 32'(e));
                end
            end
            if (err_pulse) err_seen++;
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_sof", 32'(out_sof), 32'd0);
        check("reset out_eof", 32'(out_eof), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset frame_count", 32'(frame_count), 32'd0);
        check("reset err_pulse", 32'(err_pulse), 32'd0);
        check("reset err_code", 32'(err_code), 32'd0);
        @(posedge clk);
        #1 SW0 = 1'b0;
        idle(4);

        // Good frame, consumer always ready.
        set_ready(1'b1);
        e0 = err_seen;
        push_frame(50, 1'b1);
        send_frame(15, 4'hD, 100, -1);
        wait_drain("s1");
        check("s1 frame_count", 32'(frame_count), 32'd1);
        check("s1 err pulses", 32'(err_seen - e0), 32'd0);

        // Overflow of a 32-entry FIFO with consumer stalled.
        do_reset();
        set_ready(1'b0);
        e0 = err_seen;
        push_frame(32, 1'b0);
        send_frame(15, 4'hD, 100, -1);
        check("s2 err pulses", 32'(err_seen - e0), 32'd1);
        check("s2 err_code", 32'(err_code), 32'd3);
        check("s2 frame_count", 32'(frame_count), 32'd0);
        check("s2 held valid", 32'(out_valid), 32'd1);
        set_ready(1'b1);
        push_frame(50, 1'b1);
        send_frame(15, 4'hD, 100, -1);
        wait_drain("s2");
        check("s2 frame_count after", 32'(frame_count), 32'd1);

        // Preamble too short.
        e0 = err_seen;
        send_frame(2, 4'hD, 16, -1);
        check("s3 err pulses", 32'(err_seen - e0), 32'd1);
        check("s3 err_code", 32'(err_code), 32'd1);
        push_frame(50, 1'b1);
        send_frame(15, 4'hD, 100, -1);
        wait_drain("s3");
        check("s3 frame_count", 32'(frame_count), 32'd2);

        // Odd nibble count: 7 bytes, last tagged eof.
        e0 = err_seen;
        push_frame(7, 1'b1);
        send_frame(15, 4'hD, 15, -1);
        wait_drain("s4");
        check("s4 err pulses", 32'(err_seen - e0), 32'd1);
        check("s4 err_code", 32'(err_code), 32'd2);
        check("s4 frame_count", 32'(frame_count), 32'd2);

        // Reset mid-payload with en held high.
        do_reset();
        set_ready(1'b0);
        e0 = err_seen;
        send_frame(15, 4'hD, 100, 40);
        check("s5 valid after frame", 32'(out_valid), 32'd0);
        check("s5 err pulses", 32'(err_seen - e0), 32'd0);
        check("s5 err_code", 32'(err_code), 32'd0);
        check("s5 frame_count", 32'(frame_count), 32'd0);
        set_ready(1'b1);
        push_frame(50, 1'b1);
        send_frame(15, 4'hD, 100, -1);
        wait_drain("s5");
        check("s5 frame_count after", 32'(frame_count), 32'd1);

        // Consumer ready toggling every clk.
        @(posedge clk);
        #1 toggle_en = 1'b1;
        e0 = err_seen;
        push_frame(50, 1'b1);
        send_frame(15, 4'hD, 100, -1);
        wait_drain("s6");
        @(posedge clk);
        #1 toggle_en = 1'b0;
        check("s6 frame_count", 32'(frame_count), 32'd2);
        check("s6 err pulses", 32'(err_seen - e0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
